host_cmd_master: RTL and testbench
==================================

// Module: host_cmd_master
// PURPOSE
// - Bus master that drives the sap2 host bus: buffers requests from a req/rsp client, issues them one at a time
//   as single-cycle host commands, waits for read data, and returns exactly one response per accepted request.
// - Sits directly upstream of sap2. Adds address-window checking, read timeout and response backpressure.
// PARAMETERS
// - DEPTH       4             request FIFO entries; power of 2, >=2
// - TIMEOUT     16            max cycles waited for host_rd_vld after a read issue; range 1..255
// - WIN_BASE    32'hA000_0000 lowest legal address (sap1_0 base)
// - WIN_LIMIT   32'hC000_0000 first illegal address above the window (sap1_1 base + size)
// - ERR_DATA    32'hDEAD_BEEF rsp_data returned on read error
// PORTS
// - clk          in   1   clock, all logic on rising edge
// - reset        in   1   asynchronous, active-low reset
// - req_vld      in   1   request valid
// - req_rdy      out  1   request ready (FIFO not full); transfer when req_vld & req_rdy
// - req_rw       in   1   1=read, 0=write
// - req_addr     in   32  byte address
// - req_data     in   32  write data (ignored for reads)
// - rsp_vld      out  1   response valid; held until rsp_rdy
// - rsp_rdy      in   1   response ready
// - rsp_rw       out  1   echo of request rw
// - rsp_data     out  32  read data; 0 for writes
// - rsp_err      out  1   1=address out of window or read timeout
// - host_cmd_vld out  1   host command strobe, one cycle per command
// - host_rw      out  1   1=read, 0=write
// - host_addr    out  32  host address
// - host_data_w  out  32  host write data
// - host_data_r  in   32  host read data, valid with host_rd_vld
// - host_rd_vld  in   1   host read-data strobe
// - spurious_cnt out  8   saturating count of host_rd_vld seen outside WAIT_RD
// BEHAVIOUR
// - Reset (reset=0, async): FIFO empty, FSM=IDLE, all outputs 0 except req_rdy=1 after reset deasserts; spurious_cnt=0.
// - FIFO: DEPTH entries {rw,addr,data}; req_rdy = !full; push and pop in the same cycle allowed at full
//   (req_rdy stays 0 at full, no same-cycle bypass); pointers wrap modulo DEPTH.
// - FSM states: IDLE, ISSUE, WAIT_RD, RESP.
// - IDLE: if FIFO non-empty, pop head into command register -> ISSUE.
// - ISSUE (1 cycle): if addr < WIN_BASE or addr >= WIN_LIMIT: no host strobe, load rsp err=1, data=ERR_DATA
//   for read / 0 for write -> RESP. Else host_cmd_vld=1 with rw/addr/data_w registered outputs;
//   write -> RESP (err=0, data=0); read -> WAIT_RD, timer cleared.
// - WAIT_RD: timer increments each cycle; host_rd_vld=1 -> capture host_data_r, err=0 -> RESP.
//   timer reaches TIMEOUT with no strobe -> err=1, data=ERR_DATA -> RESP. Strobe on the TIMEOUT cycle wins (no error).
// - RESP: rsp_vld=1, fields stable; rsp_rdy=1 -> IDLE (next issue no earlier than 2 cycles later).
// - Latency: write req accepted in cycle N (empty FIFO, rsp_rdy=1): host_cmd_vld at N+2, rsp_vld at N+3.
//   Read: rsp_vld one cycle after host_rd_vld.
// - Host outputs other than host_cmd_vld hold last value between commands; host_cmd_vld never 2 consecutive cycles.
// - host_rd_vld outside WAIT_RD: ignored for data, spurious_cnt += 1, saturates at 255.
// - Strictly in-order; one outstanding host command maximum.
// - Reset mid-operation: in-flight command and FIFO contents discarded, no response emitted.
// STRUCTURE
// - Package host_cmd_pkg: typedef struct packed {logic rw; logic [31:0] addr; logic [31:0] data;} host_req_t;
//   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} hcm_state_e; default window constants.
// - Sub-module host_req_fifo (parameterised DEPTH, host_req_t payload, full/empty); FSM, timer, counter in top.
// TESTING
// - Write 0xA000_0010 data 0x1234_5678 -> one host_cmd_vld, rw=0; rsp_vld 3 cycles after accept, err=0, data=0.
// - Read 0xB000_0004, model returns 0xCAFE_0001 after 3 cycles -> rsp data=0xCAFE_0001, err=0.
// - Read 0x9000_0000 and write 0xC000_0000 -> no host_cmd_vld; rsp err=1, data 0xDEAD_BEEF / 0.
// - Read with no slave reply -> rsp after TIMEOUT=16 cycles, err=1, data=0xDEAD_BEEF; rd_vld on cycle 16 -> err=0.
// - Push 6 requests with rsp_rdy=0 -> req_rdy=0 after 4 buffered (+1 held); release -> 6 in-order responses.
// - Three host_rd_vld pulses in IDLE -> spurious_cnt=3; 300 pulses -> 255; async reset mid WAIT_RD -> all cleared, no rsp.

Source files
------------

// File: rtl/host_cmd_pkg.sv
// host_cmd_pkg: request payload, FSM state type and default address-window constants
// shared by host_cmd_master and its request FIFO.
package host_cmd_pkg;
    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } host_req_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} hcm_state_e;
    localparam logic [31:0] DEF_WIN_BASE  = 32'hA000_0000;
    localparam logic [31:0] DEF_WIN_LIMIT = 32'hC000_0000;
    localparam logic [31:0] DEF_ERR_DATA  = 32'hDEAD_BEEF;
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                       input logic [31:0] limit);
        return (addr >= base) && (addr < limit);
    endfunction
endpackage

// File: rtl/host_req_fifo.sv
// host_req_fifo: DEPTH-entry request FIFO; push is ignored when full, pop when empty,
// no same-cycle bypass from push to head.
module host_req_fifo
    import host_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  host_req_t push_data,
    input  logic      pop,
    output host_req_t head,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);
    host_req_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;
    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign head  = mem_q[rd_ptr_q];
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/host_cmd_master.sv
// host_cmd_master: buffers client requests and issues them one at a time on the sap2 host bus,
// with address-window checking, read timeout and response backpressure.
module host_cmd_master
    import host_cmd_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] WIN_BASE  = DEF_WIN_BASE,
    parameter logic [31:0] WIN_LIMIT = DEF_WIN_LIMIT,
    parameter logic [31:0] ERR_DATA  = DEF_ERR_DATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic        req_rw,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic        rsp_rw,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        host_cmd_vld,
    output logic        host_rw,
    output logic [31:0] host_addr,
    output logic [31:0] host_data_w,
    input  logic [31:0] host_data_r,
    input  logic        host_rd_vld,
    output logic [7:0]  spurious_cnt
);
    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);
    hcm_state_e  state_q, state_d;
    logic        cmd_rw_q, cmd_rw_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [7:0]  timer_q, timer_d;
    logic        host_cmd_vld_q, host_cmd_vld_d, host_rw_q, host_rw_d;
    logic [31:0] host_addr_q, host_addr_d, host_data_w_q, host_data_w_d;
    logic        rsp_vld_q, rsp_vld_d, rsp_rw_q, rsp_rw_d, rsp_err_q, rsp_err_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [7:0]  spurious_q, spurious_d;
    logic        pop, full, empty;
    host_req_t   head, push_data;
    assign push_data = {req_rw, req_addr, req_data};
    host_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_vld),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );
    assign req_rdy      = !full;
    assign rsp_vld      = rsp_vld_q;
    assign rsp_rw       = rsp_rw_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign host_cmd_vld = host_cmd_vld_q;
    assign host_rw      = host_rw_q;
    assign host_addr    = host_addr_q;
    assign host_data_w  = host_data_w_q;
    assign spurious_cnt = spurious_q;
    // Host outputs are loaded at pop time so the strobe lands in the ISSUE cycle.
    always_comb begin
        state_d        = state_q;
        cmd_rw_d       = cmd_rw_q;
        cmd_addr_d     = cmd_addr_q;
        timer_d        = timer_q;
        host_cmd_vld_d = 1'b0;
        host_rw_d      = host_rw_q;
        host_addr_d    = host_addr_q;
        host_data_w_d  = host_data_w_q;
        rsp_vld_d      = rsp_vld_q;
        rsp_rw_d       = rsp_rw_q;
        rsp_data_d     = rsp_data_q;
        rsp_err_d      = rsp_err_q;
        pop            = 1'b0;
        spurious_d     = (host_rd_vld && state_q != WAIT_RD && spurious_q != 8'hFF)
                         ? spurious_q + 8'd1 : spurious_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    cmd_rw_d   = head.rw;
                    cmd_addr_d = head.addr;
                    state_d    = ISSUE;
                    if (in_window(head.addr, WIN_BASE, WIN_LIMIT)) begin
                        host_cmd_vld_d = 1'b1;
                        host_rw_d      = head.rw;
                        host_addr_d    = head.addr;
                        host_data_w_d  = head.data;
                    end
                end
            end
            ISSUE: begin
                rsp_rw_d = cmd_rw_q;
                if (!in_window(cmd_addr_q, WIN_BASE, WIN_LIMIT)) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = cmd_rw_q ? ERR_DATA : '0;
                    rsp_vld_d  = 1'b1;
                    state_d    = RESP;
                end else if (cmd_rw_q) begin
                    timer_d = '0;
                    state_d = WAIT_RD;
                end else begin
                    rsp_err_d  = 1'b0;
                    rsp_data_d = '0;
                    rsp_vld_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            WAIT_RD: begin
                if (host_rd_vld) begin
                    rsp_err_d  = 1'b0;
                    rsp_data_d = host_data_r;
                    rsp_vld_d  = 1'b1;
                    state_d    = RESP;
                end else if (timer_q == TMAX) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = ERR_DATA;
                    rsp_vld_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_rdy) begin
                    rsp_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cmd_rw_q       <= 1'b0;
            cmd_addr_q     <= '0;
            timer_q        <= '0;
            host_cmd_vld_q <= 1'b0;
            host_rw_q      <= 1'b0;
            host_addr_q    <= '0;
            host_data_w_q  <= '0;
            rsp_vld_q      <= 1'b0;
            rsp_rw_q       <= 1'b0;
            rsp_data_q     <= '0;
            rsp_err_q      <= 1'b0;
            spurious_q     <= '0;
        end else begin
            state_q        <= state_d;
            cmd_rw_q       <= cmd_rw_d;
            cmd_addr_q     <= cmd_addr_d;
            timer_q        <= timer_d;
            host_cmd_vld_q <= host_cmd_vld_d;
            host_rw_q      <= host_rw_d;
            host_addr_q    <= host_addr_d;
            host_data_w_q  <= host_data_w_d;
            rsp_vld_q      <= rsp_vld_d;
            rsp_rw_q       <= rsp_rw_d;
            rsp_data_q     <= rsp_data_d;
            rsp_err_q      <= rsp_err_d;
            spurious_q     <= spurious_d;
        end
    end
endmodule

// File: tb/tb_host_cmd_master.sv
// tb_host_cmd_master: directed scenarios plus a randomized run scored against a
// request-level model of the expected host commands and responses.
module tb_host_cmd_master;
    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } item_t;

    logic        clk = 0, reset = 0;
    logic        req_vld = 0, req_rdy, req_rw = 0;
    logic [31:0] req_addr = 0, req_data = 0;
    logic        rsp_vld, rsp_rdy = 0, rsp_rw, rsp_err;
    logic [31:0] rsp_data;
    logic        host_cmd_vld, host_rw, host_rd_vld;
    logic [31:0] host_addr, host_data_w, host_data_r = 0;
    logic [7:0]  spurious_cnt;
    logic        slv_vld = 0, inj_vld = 0;
    logic        ovr_en = 0, mon_en = 0;
    int          ovr_delay = 0;
    logic [31:0] ovr_data = 0;
    int          checks = 0, passes = 0;
    item_t       hq[$];
    int          slv_cnt = 0;
    logic [31:0] slv_dat = 0;
    logic        prev_cmd = 0;

    assign host_rd_vld = slv_vld | inj_vld;

    host_cmd_master dut (
        .clk(clk), .reset(reset),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rw(rsp_rw), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .host_cmd_vld(host_cmd_vld), .host_rw(host_rw), .host_addr(host_addr), .host_data_w(host_data_w),
        .host_data_r(host_data_r), .host_rd_vld(host_rd_vld), .spurious_cnt(spurious_cnt)
    );

    always #5 clk = ~clk;

    // Slave stimulus mapping: address bits [6:2] give the reply delay, 0 or >16 means no reply.
    function automatic int delay_of(input logic [31:0] a);
        int d;
        d = int'(a[6:2]);
        return (d > 16) ? 0 : d;
    endfunction

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return ~a ^ 32'h0F0F_0000;
    endfunction

    function automatic item_t model_rsp(input logic rw, input logic [31:0] a);
        item_t r;
        logic inwin;
        inwin = (a >= 32'hA000_0000) && (a < 32'hC000_0000);
        r.rw = rw;
        r.addr = a;
        if (!inwin) begin r.err = 1; r.data = rw ? 32'hDEAD_BEEF : 32'h0; end
        else if (!rw) begin r.err = 0; r.data = 0; end
        else if (delay_of(a) == 0) begin r.err = 1; r.data = 32'hDEAD_BEEF; end
        else begin r.err = 0; r.data = data_of(a); end
        return r;
    endfunction

    // Host slave and host-command monitor; outputs read and inputs set on the falling edge.
    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            slv_vld = 0;
            host_data_r = $urandom;
            if (!reset) begin
                slv_cnt = 0;
                prev_cmd = 0;
            end else begin
                if (slv_cnt > 0) begin
                    slv_cnt--;
                    if (slv_cnt == 0) begin slv_vld = 1; host_data_r = slv_dat; end
                end
                if (host_cmd_vld) begin
                    checks++;
                    if (prev_cmd) $display("FAIL cmd_gap: host_cmd_vld high two cycles in a row at %0t", $time);
                    else passes++;
                    if (host_rw) begin
                        slv_cnt = ovr_en ? ovr_delay : delay_of(host_addr);
                        slv_dat = ovr_en ? ovr_data : data_of(host_addr);
                    end
                    if (mon_en) begin
                        checks++;
                        if (hq.size() == 0) $display("FAIL host_cmd: unexpected command addr=%h", host_addr);
                        else begin
                            e = hq.pop_front();
                            if (host_rw !== e.rw || host_addr !== e.addr || (!e.rw && host_data_w !== e.data))
                                $display("FAIL host_cmd: got rw=%0b addr=%h wdata=%h want rw=%0b addr=%h wdata=%h",
                                         host_rw, host_addr, host_data_w, e.rw, e.addr, e.data);
                            else passes++;
                        end
                    end
                end
                prev_cmd = host_cmd_vld;
            end
        end
    end

    task automatic do_req(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                          output int t_cmd, output int n_cmd, output logic c_rw, output logic [31:0] c_addr,
                          output logic [31:0] c_dw, output int t_rsp, output logic r_rw,
                          output logic [31:0] r_data, output logic r_err);
        int w;
        t_cmd = -1; n_cmd = 0; c_rw = 0; c_addr = 0; c_dw = 0;
        t_rsp = -1; r_rw = 0; r_data = 0; r_err = 0;
        rsp_rdy = 1;
        @(negedge clk);
        req_rw = rw; req_addr = addr; req_data = data; req_vld = 1;
        w = 0;
        while (!req_rdy && w < 20) begin @(negedge clk); w++; end
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            req_vld = 0;
            if (host_cmd_vld) begin
                if (t_cmd < 0) begin t_cmd = k; c_rw = host_rw; c_addr = host_addr; c_dw = host_data_w; end
                n_cmd++;
            end
            if (rsp_vld && t_rsp < 0) begin t_rsp = k; r_rw = rsp_rw; r_data = rsp_data; r_err = rsp_err; end
        end
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rsp_vld, host_cmd_vld, rsp_err, spurious_cnt, host_addr, rsp_data} !== '0)
            $display("FAIL reset_outs: rsp_vld=%0b cmd=%0b err=%0b spur=%0d haddr=%h rdata=%h want all 0",
                     rsp_vld, host_cmd_vld, rsp_err, spurious_cnt, host_addr, rsp_data);
        else passes++;
        reset = 1;
        @(negedge clk);
        checks++;
        if (req_rdy !== 1'b1) $display("FAIL reset_rdy: req_rdy=%0b want 1", req_rdy); else passes++;
    endtask

    task automatic test_write();
        int tc, nc, tr; logic crw, rrw, rerr; logic [31:0] ca, cd, rd;
        do_req(1'b0, 32'hA000_0010, 32'h1234_5678, tc, nc, crw, ca, cd, tr, rrw, rd, rerr);
        checks++; if (tc !== 2 || nc !== 1) $display("FAIL wr_cmd_timing: t=%0d n=%0d want t=2 n=1", tc, nc); else passes++;
        checks++; if ({crw, ca, cd} !== {1'b0, 32'hA000_0010, 32'h1234_5678})
            $display("FAIL wr_cmd_fields: rw=%0b addr=%h data=%h want 0 a0000010 12345678", crw, ca, cd); else passes++;
        checks++; if (tr !== 3) $display("FAIL wr_rsp_latency: %0d want 3", tr); else passes++;
        checks++; if ({rrw, rerr, rd} !== {1'b0, 1'b0, 32'h0})
            $display("FAIL wr_rsp_fields: rw=%0b err=%0b data=%h want 0 0 0", rrw, rerr, rd); else passes++;
    endtask

    task automatic test_read();
        int tc, nc, tr; logic crw, rrw, rerr; logic [31:0] ca, cd, rd;
        ovr_en = 1; ovr_delay = 3; ovr_data = 32'hCAFE_0001;
        do_req(1'b1, 32'hB000_0004, 32'h0, tc, nc, crw, ca, cd, tr, rrw, rd, rerr);
        checks++; if (tc !== 2 || nc !== 1 || crw !== 1'b1 || ca !== 32'hB000_0004)
            $display("FAIL rd_cmd: t=%0d n=%0d rw=%0b addr=%h want 2 1 1 b0000004", tc, nc, crw, ca); else passes++;
        checks++; if (tr !== 6) $display("FAIL rd_rsp_latency: %0d want 6", tr); else passes++;
        checks++; if ({rrw, rerr, rd} !== {1'b1, 1'b0, 32'hCAFE_0001})
            $display("FAIL rd_rsp_fields: rw=%0b err=%0b data=%h want 1 0 cafe0001", rrw, rerr, rd); else passes++;
        ovr_en = 0;
    endtask

    task automatic test_window_err();
        int tc, nc, tr; logic crw, rrw, rerr; logic [31:0] ca, cd, rd;
        do_req(1'b1, 32'h9000_0000, 32'h0, tc, nc, crw, ca, cd, tr, rrw, rd, rerr);
        checks++; if (nc !== 0) $display("FAIL win_rd_nocmd: %0d commands want 0", nc); else passes++;
        checks++; if ({tr, rrw, rerr, rd} !== {32'd3, 1'b1, 1'b1, 32'hDEAD_BEEF})
            $display("FAIL win_rd_rsp: t=%0d rw=%0b err=%0b data=%h want 3 1 1 deadbeef", tr, rrw, rerr, rd); else passes++;
        do_req(1'b0, 32'hC000_0000, 32'h7777_7777, tc, nc, crw, ca, cd, tr, rrw, rd, rerr);
        checks++; if (nc !== 0) $display("FAIL win_wr_nocmd: %0d commands want 0", nc); else passes++;
        checks++; if ({tr, rrw, rerr, rd} !== {32'd3, 1'b0, 1'b1, 32'h0})
            $display("FAIL win_wr_rsp: t=%0d rw=%0b err=%0b data=%h want 3 0 1 0", tr, rrw, rerr, rd); else passes++;
    endtask

    task automatic test_timeout();
        int tc, nc, tr; logic crw, rrw, rerr; logic [31:0] ca, cd, rd;
        ovr_en = 1; ovr_delay = 0;
        do_req(1'b1, 32'hA000_0200, 32'h0, tc, nc, crw, ca, cd, tr, rrw, rd, rerr);
        checks++; if ({tr, rerr, rd} !== {32'd19, 1'b1, 32'hDEAD_BEEF})
            $display("FAIL timeout_rsp: t=%0d err=%0b data=%h want 19 1 deadbeef", tr, rerr, rd); else passes++;
        ovr_delay = 16; ovr_data = 32'h5555_AAAA;
        do_req(1'b1, 32'hA000_0300, 32'h0, tc, nc, crw, ca, cd, tr, rrw, rd, rerr);
        checks++; if ({tr, rerr, rd} !== {32'd19, 1'b0, 32'h5555_AAAA})
            $display("FAIL timeout_edge: t=%0d err=%0b data=%h want 19 0 5555aaaa", tr, rerr, rd); else passes++;
        checks++; if (spurious_cnt !== 8'd0) $display("FAIL timeout_spur: %0d want 0", spurious_cnt); else passes++;
        ovr_en = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [6];
        int idx, got;
        for (int i = 0; i < 6; i++) addrs[i] = 32'hA000_0000 + 32'(4 * (i + 1));
        rsp_rdy = 0; idx = 0; got = 0;
        @(negedge clk);
        for (int k = 0; k < 15; k++) begin
            if (idx < 6) begin req_vld = 1; req_rw = 1; req_addr = addrs[idx]; end else req_vld = 0;
            if (req_vld && req_rdy) idx++;
            @(negedge clk);
        end
        checks++; if (idx !== 5 || req_rdy !== 1'b0)
            $display("FAIL bp_fill: accepted=%0d req_rdy=%0b want 5 0", idx, req_rdy); else passes++;
        checks++; if (rsp_vld !== 1'b1 || rsp_data !== data_of(addrs[0]))
            $display("FAIL bp_hold: rsp_vld=%0b data=%h want 1 %h", rsp_vld, rsp_data, data_of(addrs[0])); else passes++;
        rsp_rdy = 1;
        for (int k = 0; k < 300 && got < 6; k++) begin
            if (idx < 6) begin req_vld = 1; req_rw = 1; req_addr = addrs[idx]; end else req_vld = 0;
            if (req_vld && req_rdy) idx++;
            if (rsp_vld) begin
                checks++;
                if (rsp_data !== data_of(addrs[got]) || rsp_err !== 1'b0 || rsp_rw !== 1'b1)
                    $display("FAIL bp_order[%0d]: data=%h err=%0b want %h 0", got, rsp_data, rsp_err, data_of(addrs[got]));
                else passes++;
                got++;
            end
            @(negedge clk);
        end
        req_vld = 0;
        checks++; if (got !== 6) $display("FAIL bp_count: %0d responses want 6", got); else passes++;
    endtask

    task automatic test_random();
        item_t exp_q[$];
        item_t e, c;
        int sent, got, sel;
        logic acc;
        logic [31:0] a;
        sent = 0; got = 0; acc = 0; mon_en = 1;
        for (int cyc = 0; cyc < 4000 && got < 40; cyc++) begin
            @(negedge clk);
            if (acc) req_vld = 0;
            acc = 0;
            rsp_rdy = ($urandom_range(3) != 0);
            if (rsp_vld && rsp_rdy) begin
                checks++;
                if (exp_q.size() == 0) $display("FAIL rnd_rsp: unexpected response data=%h", rsp_data);
                else begin
                    e = exp_q.pop_front();
                    if (rsp_rw !== e.rw || rsp_err !== e.err || rsp_data !== e.data)
                        $display("FAIL rnd_rsp: addr=%h got rw=%0b err=%0b data=%h want rw=%0b err=%0b data=%h",
                                 e.addr, rsp_rw, rsp_err, rsp_data, e.rw, e.err, e.data);
                    else passes++;
                end
                got++;
            end
            if (!req_vld && sent < 40 && $urandom_range(1) == 1) begin
                sel = $urandom_range(7);
                case (sel)
                    0: a = $urandom_range(32'h9FFF_FFFF);
                    1: a = 32'h9FFF_FFFF;
                    2: a = 32'hA000_0000;
                    3: a = 32'hBFFF_FFFF;
                    4: a = 32'hC000_0000;
                    5: a = 32'hC000_0000 + $urandom_range(32'h3FFF_FFFF);
                    default: a = 32'hA000_0000 + $urandom_range(32'h1FFF_FFFF);
                endcase
                req_addr = a; req_rw = $urandom_range(1) == 1; req_data = $urandom; req_vld = 1;
            end
            if (req_vld && req_rdy) begin
                e = model_rsp(req_rw, req_addr);
                exp_q.push_back(e);
                if ((req_addr >= 32'hA000_0000) && (req_addr < 32'hC000_0000)) begin
                    c.rw = req_rw; c.addr = req_addr; c.data = req_data; c.err = 0;
                    hq.push_back(c);
                end
                sent++; acc = 1;
            end
        end
        @(negedge clk);
        req_vld = 0; mon_en = 0;
        checks++; if (got !== 40 || exp_q.size() != 0 || hq.size() != 0)
            $display("FAIL rnd_done: got=%0d pending_rsp=%0d pending_cmd=%0d want 40 0 0", got, exp_q.size(), hq.size());
        else passes++;
        checks++; if (spurious_cnt !== 8'd0) $display("FAIL rnd_spur: %0d want 0", spurious_cnt); else passes++;
    endtask

    task automatic test_spurious_and_reset();
        int seen;
        rsp_rdy = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); inj_vld = 1;
            @(negedge clk); inj_vld = 0;
        end
        repeat (2) @(negedge clk);
        checks++; if (spurious_cnt !== 8'd3) $display("FAIL spur_three: %0d want 3", spurious_cnt); else passes++;
        inj_vld = 1;
        repeat (300) @(negedge clk);
        inj_vld = 0;
        @(negedge clk);
        checks++; if (spurious_cnt !== 8'd255) $display("FAIL spur_sat: %0d want 255", spurious_cnt); else passes++;
        ovr_en = 1; ovr_delay = 0;
        req_vld = 1; req_rw = 1; req_addr = 32'hA000_1000;
        @(negedge clk); req_rw = 0; req_addr = 32'hA000_2000; req_data = 32'h1111_1111;
        @(negedge clk); req_addr = 32'hA000_3000;
        @(negedge clk); req_vld = 0;
        repeat (4) @(negedge clk);
        #2 reset = 0;
        #1;
        checks++;
        if ({rsp_vld, host_cmd_vld, spurious_cnt, host_addr, rsp_data} !== '0 || req_rdy !== 1'b1)
            $display("FAIL async_reset: rsp_vld=%0b cmd=%0b spur=%0d haddr=%h rdata=%h req_rdy=%0b want zeros, rdy 1",
                     rsp_vld, host_cmd_vld, spurious_cnt, host_addr, rsp_data, req_rdy);
        else passes++;
        repeat (2) @(negedge clk);
        reset = 1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_vld || host_cmd_vld) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL reset_discard: %0d active cycles after reset want 0", seen); else passes++;
        ovr_en = 0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_window_err();
        test_timeout();
        test_back_to_back();
        test_random();
        test_spurious_and_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
